// File: rtl/iter_integer_linear_calc.sv
// Free-running y = m*x + b calculator.
// Shift-add multiply, one multiplier bit per clock.
module iter_integer_linear_calc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        LOAD = 1'b0,
        MULT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    count;
    logic             load;
    logic             done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: state_d = MULT;
            MULT: if (count == LAST) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        load = 1'b0;
        done = 1'b0;
        unique case (state_q)
            LOAD: load = 1'b1;
            MULT: done = (count == LAST);
            default: load = 1'b1;
        endcase
    end

    // The final add is folded into y on the last iteration.
    assign acc_nxt = x_r[0] ? acc + m_r : acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_r   <= '0;
            x_r   <= '0;
            acc   <= '0;
            count <= '0;
            y     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            m_r   <= m;
            x_r   <= x;
            acc   <= b;
            count <= '0;
            valid <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            m_r   <= m_r << 1;
            x_r   <= x_r >> 1;
            count <= count + CW'(1);
            valid <= done;
            if (done) begin
                y <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_iter_integer_linear_calc.sv
// Bench for iter_integer_linear_calc.
// Reference model: operands captured each period, y = m*x+b mod 2^32.
module tb_iter_integer_linear_calc;

    localparam int PER = 33;

    logic        clk;
    logic        rst;
    logic [31:0] m;
    logic [31:0] x;
    logic [31:0] b;
    logic [31:0] y;
    logic        valid;

    int          n_vec;
    int          n_err;
    int          edge_n;
    logic [31:0] sm;
    logic [31:0] sx;
    logic [31:0] sb;
    logic [31:0] exp_y;
    logic        exp_v;

    iter_integer_linear_calc #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .m     (m),
        .x     (x),
        .b     (b),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: advance the model on the edge, check #1 later.
    task automatic tick();
        @(posedge clk);
        exp_v = 1'b0;
        if (rst) begin
            edge_n++;
            if (edge_n % PER == 1) begin
                sm = m;
                sx = x;
                sb = b;
            end
            if (edge_n % PER == 0) begin
                exp_y = sm * sx + sb;
                exp_v = 1'b1;
            end
        end
        #1;
        chk("valid", {31'b0, valid}, {31'b0, exp_v});
        chk("y", y, exp_y);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic align(input int phase);
        for (int i = 0; i < 2 * PER && (edge_n % PER) != phase; i++)
            tick();
    endtask

    task automatic model_reset();
        edge_n = 0;
        exp_y  = '0;
        exp_v  = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        sm = '0;
        sx = '0;
        sb = '0;
        model_reset();

        rst = 1'b0;
        m = '0;
        x = '0;
        b = '0;
        #2;
        chk("rst_y", y, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        run(3);
        rst = 1'b1;

        // Zero operands: pulses at edges 33 and 66.
        run(32);
        chk("pre_pulse_valid", {31'b0, valid}, 32'd0);
        tick();
        chk("first_pulse", {31'b0, valid}, 32'd1);
        tick();
        chk("pulse_width", {31'b0, valid}, 32'd0);
        run(40);

        b = 32'd10;
        run(7);
        m = 32'd11;
        x = 32'd16;
        run(2 * PER);
        align(0);
        chk("y_186", y, 32'd186);
        run(PER);
        chk("y_186_again", y, 32'd186);

        m = 32'd7;
        x = 32'd12;
        run(2 * PER);
        align(0);
        chk("y_94", y, 32'd94);

        m = 32'hFFFF_FFFF;
        x = 32'd2;
        b = 32'd3;
        run(2 * PER);
        align(0);
        chk("ovf_a", y, 32'd1);

        x = 32'hFFFF_FFFF;
        b = 32'd0;
        run(2 * PER);
        align(0);
        chk("ovf_b", y, 32'd1);

        // Random operand sets, each held for two periods.
        for (int k = 0; k < 6; k++) begin
            m = $urandom;
            x = $urandom;
            b = $urandom;
            run(2 * PER);
        end

        // Asynchronous reset ~15 cycles into MULT.
        m = 32'd5;
        x = 32'd5;
        b = 32'd5;
        run(PER);
        align(16);
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_y", y, 32'd0);
        chk("async_valid", {31'b0, valid}, 32'd0);
        run(2);
        rst = 1'b1;
        run(32);
        tick();
        chk("post_rst_valid", {31'b0, valid}, 32'd1);
        chk("post_rst_y", y, 32'd30);

        // x glitch while a multiply is in flight.
        m = 32'd3;
        x = 32'd4;
        b = 32'd1;
        run(PER);
        align(1);
        run(5);
        x = 32'd9;
        run(5);
        x = 32'd4;
        align(0);
        chk("glitch_y", y, 32'd13);
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iter_integer_linear_calc.md
Name: iter_integer_linear_calc

Overview:
- Computes y = m*x + b on unsigned 32-bit integers with an iterative shift-add multiplier (one multiplier bit per clock), so no hardware multiplier is needed.
- Free-running: the block continuously samples its operands, computes the result, publishes y and pulses valid, then starts again.
- Used as a low-area calibration/linear-transform stage where operands change slowly compared with the roughly 33-cycle update period.

Parameters:
- WIDTH, 32, operand/result width; ports below are shown at the default value.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset; asynchronous, active-low.
- m  input  32  slope operand (unsigned).
- x  input  32  input operand (unsigned).
- b  input  32  offset operand (unsigned).
- y  output  32  registered result m*x+b mod 2^32; held between updates.
- valid  output  1  one-cycle pulse, high in the cycle after y is updated.

Behaviour:
- Reset (rst=0, asynchronous):
  - y=0, valid=0.
  - Internal m_r/x_r/acc/count cleared; state=LOAD.
  - Takes effect immediately, including mid-computation; any partial result is discarded.
- State machine has two states, LOAD and MULT.
- LOAD, one cycle:
  - m_r<=m, x_r<=x, acc<=b, count<=0.
  - valid<=0.
  - Next state MULT.
- MULT, exactly WIDTH cycles, with no early termination:
  - Each edge: if x_r[0], acc<=acc+m_r (mod 2^WIDTH); then m_r<=m_r<<1, x_r<=x_r>>1, count<=count+1.
  - On the WIDTH-th MULT edge (count==WIDTH-1), y<=final acc including that iteration's add, and valid<=1.
  - Next state LOAD.
- Timing:
  - Period is WIDTH+1 = 33 cycles.
  - First sampling edge is the first rising edge after rst deasserts.
  - y/valid update 32 edges after each sampling edge.
  - valid is high for exactly one cycle per period; it is low in all other cycles, including the cycle in which the next LOAD occurs.
- Operand sampling:
  - Operands are sampled only in LOAD.
  - Changes on m/x/b during MULT do not affect the result in progress; they appear in the next period.
  - New inputs therefore take at most 2 periods (66 cycles) to reach y.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - Overflow bits are discarded; there is no saturation or overflow flag.
- y holds its last value between valid pulses. It is the same value recomputed each period if the operands are static.
- No handshake and no back-pressure; consumers capture y when valid=1.

Test Plan:
- Reset, then hold m=0, x=0, b=0 → first valid pulse 33 edges after reset release with y=0; valid pulses repeat every 33 cycles, each exactly one cycle wide.
- b=10, then m=11, x=16 → within 66 cycles y=186 with valid pulse; y stays 186 on every later pulse.
- Change to m=7, x=12 (b=10) → within 66 cycles y=94; the period in which inputs changed still reports 186 if sampling preceded the change.
- Overflow: m=0xFFFFFFFF, x=2, b=3 → y=0x00000001. Also m=0xFFFFFFFF, x=0xFFFFFFFF, b=0 → y=0x00000001.
- Mid-computation reset: assert rst low about 15 cycles into MULT with m=5, x=5, b=5 → y=0 and valid=0 immediately and asynchronously. After release, first pulse is 33 edges later with y=30.
- Input glitch during MULT: toggle x 4→9→4 while in MULT with m=3, b=1 → that period's y=13, unaffected by the glitch.
